reg_wb_ctrl: RTL and testbench
==============================

// Module: reg_wb_ctrl
// PURPOSE
//   Write-port controller for the 32x32 register file (we/waddr/wdata). Merges pipeline
//   writebacks with results from the multi-cycle mul/div unit (MDU); buffers MDU results in a FIFO.
//   Drives exactly one registered write per cycle and exports a pending-write mask for ID-stage stalls.
// PARAMETERS
//   DEPTH  4  MDU FIFO entries (power of 2, >=2)
//   AW     2  log2(DEPTH), FIFO pointer width
// PORTS
//   clk         in   1   clock
//   rst         in   1   reset, synchronous, active-low
//   pipe_we     in   1   pipeline writeback valid (no backpressure, always accepted)
//   pipe_waddr  in   5   pipeline destination register
//   pipe_wdata  in   32  pipeline result
//   mdu_valid   in   1   MDU result valid
//   mdu_ready   out  1   FIFO can accept (= !full)
//   mdu_waddr   in   5   MDU destination register
//   mdu_wdata   in   32  MDU result
//   we          out  1   register-file write enable (registered)
//   waddr       out  5   register-file write address (registered)
//   wdata       out  32  register-file write data (registered)
//   pend_mask   out  32  bit r=1: live FIFO entry targets r; bit 0 always 0
//   fifo_cnt    out  AW+1 occupied FIFO entries, live or dead
// BEHAVIOUR
//   Reset (rst==0 at posedge): we=0, waddr=0, wdata=0, FIFO emptied (rd/wr ptr=0, cnt=0, all
//     valid/live bits 0), pend_mask=0, mdu_ready=1 from the next cycle. Reset mid-operation discards
//     queued MDU results with no write issued.
//   Push: mdu_valid && mdu_ready at posedge -> entry {waddr,wdata,live=1} written at wr_ptr, wr_ptr++.
//     mdu_waddr==0: handshake completes but nothing is enqueued (cnt unchanged).
//   mdu_ready = (fifo_cnt != DEPTH); combinational from count only, no same-cycle pop-through.
//   Output register, each posedge, priority order:
//     1. pipe_we && pipe_waddr!=0 -> we=1, waddr/wdata=pipe_*; FIFO holds.
//     2. else FIFO non-empty, head live -> we=1, waddr/wdata=head; pop.
//     3. else FIFO non-empty, head dead -> we=0; pop (dead entry discarded, costs 1 cycle).
//     4. else we=0; waddr/wdata hold their previous value.
//   pipe_we with pipe_waddr==0 counts as idle slot (rule 2/3 may apply).
//   Latency: pipeline write -> we 1 cycle; MDU accept at edge N -> earliest we at edge N+1.
//   Simultaneous push+pop: cnt unchanged, both pointers advance. Pointers wrap mod DEPTH.
//   MDU entries issue in acceptance order; pipeline never starves (MDU waits while pipe busy).
//   pend_mask = OR over occupied live entries of decode(waddr); combinational from FIFO state;
//     entry popped at edge N clears its bit after edge N.
// CONFIGURATION
//   WB_KILL_STALE_EN defined: when rule 1 fires for address r, every occupied live FIFO entry with
//     waddr==r is marked dead at the same edge (newer pipeline value must not be clobbered by an
//     older MDU result). An entry pushed at the same edge with waddr==r stays live.
//   Not defined: no kill logic; all entries written in order; ID stage must stall on pend_mask
//     to avoid WAW.
// TESTING
//   1. rst=0 two cycles with mdu_valid=1 -> we=0, pend_mask=0, fifo_cnt=0; mdu_ready=1 after release.
//   2. pipe_we=1, waddr=5, wdata=32'hDEADBEEF -> next cycle we=1, waddr=5, wdata=DEADBEEF.
//   3. Push 4 MDU results (r1..r4) while pipe_we=1 to r9 every cycle -> fifo_cnt=4, mdu_ready=0,
//      pend_mask=32'h1E; drop pipe_we -> r1,r2,r3,r4 written on 4 consecutive cycles, pend_mask->0.
//   4. Push with mdu_waddr=0 and pipe_waddr=0 -> no enqueue, we never asserts, fifo_cnt stays 0.
//   5. WB_KILL_STALE_EN: queue r7=32'h11 while pipe busy, then pipe writes r7=32'h22 -> pend_mask[7]
//      clears; later dead pop gives we=0 cycle; reg r7 ends 32'h22. Without macro: r7 ends 32'h11.
//   6. Assert rst=0 with fifo_cnt=3 -> next cycle fifo_cnt=0, we=0; no queued write ever appears.

Source files
------------

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file write port merging pipeline writebacks with a FIFO of MDU results.
// Optional feature macro WB_KILL_STALE_EN: a pipeline write kills queued MDU writes to the same register.
module reg_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_waddr,
    input  logic [31:0]   pipe_wdata,
    input  logic          mdu_valid,
    output logic          mdu_ready,
    input  logic [4:0]    mdu_waddr,
    input  logic [31:0]   mdu_wdata,
    output logic          we,
    output logic [4:0]    waddr,
    output logic [31:0]   wdata,
    output logic [31:0]   pend_mask,
    output logic [AW:0]   fifo_cnt
);
    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [DEPTH-1:0] q_live;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pipe_hit;
    logic             push;
    logic             pop;
    logic             head_live;

    assign pipe_hit  = pipe_we && (pipe_waddr != 5'd0);
    assign mdu_ready = fifo_cnt != (AW+1)'(DEPTH);
    assign push      = mdu_valid && mdu_ready && (mdu_waddr != 5'd0);
    assign pop       = !pipe_hit && (fifo_cnt != '0);
    assign head_live = q_live[rd_ptr];

    // FIFO payload storage; occupancy is tracked separately so no reset is needed here
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= mdu_waddr;
            q_data[wr_ptr] <= mdu_wdata;
        end
    end

    // Output register, FIFO pointers, occupancy and liveness; pipeline always wins the port
    always_ff @(posedge clk) begin
        if (!rst) begin
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            q_vld    <= '0;
            q_live   <= '0;
        end else begin
            we <= pipe_hit || (pop && head_live);
            if (pipe_hit) begin
                waddr <= pipe_waddr;
                wdata <= pipe_wdata;
            end else if (pop && head_live) begin
                waddr <= q_addr[rd_ptr];
                wdata <= q_data[rd_ptr];
            end
`ifdef WB_KILL_STALE_EN
            if (pipe_hit)
                for (int i = 0; i < DEPTH; i++)
                    if (q_vld[i] && q_addr[i] == pipe_waddr) q_live[i] <= 1'b0;
`endif
            if (pop) begin
                q_vld[rd_ptr]  <= 1'b0;
                q_live[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + AW'(1);
            end
            if (push) begin
                q_vld[wr_ptr]  <= 1'b1;
                q_live[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            fifo_cnt <= fifo_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Registers still owed a write by a live queued MDU result
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (q_vld[i] && q_live[i]) pend_mask[q_addr[i]] = 1'b1;
    end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl: directed plus randomized checking of reg_wb_ctrl against a queue-based model.
module tb_reg_wb_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pipe_we = 1'b0;
    logic [4:0]    pipe_waddr = '0;
    logic [31:0]   pipe_wdata = '0;
    logic          mdu_valid = 1'b0;
    logic          mdu_ready;
    logic [4:0]    mdu_waddr = '0;
    logic [31:0]   mdu_wdata = '0;
    logic          we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic [31:0]   pend_mask;
    logic [AW:0]   fifo_cnt;

    reg_wb_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic        e_we = 1'b0;
    logic [4:0]  e_waddr = '0;
    logic [31:0] e_wdata = '0;
    logic [31:0] dut_rf [32];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge, expressed on a queue of pending MDU writes
    task automatic model_edge();
        bit   hit;
        bit   acc;
        ent_t h;
        if (!rst) begin
            q.delete();
            e_we = 1'b0;
            e_waddr = '0;
            e_wdata = '0;
            return;
        end
        acc = mdu_valid && (q.size() != DEPTH) && (mdu_waddr != 5'd0);
        hit = pipe_we && (pipe_waddr != 5'd0);
        if (hit) begin
            e_we = 1'b1;
            e_waddr = pipe_waddr;
            e_wdata = pipe_wdata;
`ifdef WB_KILL_STALE_EN
            foreach (q[i]) if (q[i].a == pipe_waddr) q[i].live = 1'b0;
`endif
        end else if (q.size() > 0) begin
            h = q.pop_front();
            e_we = h.live;
            if (h.live) begin
                e_waddr = h.a;
                e_wdata = h.d;
            end
        end else begin
            e_we = 1'b0;
        end
        if (acc) q.push_back('{a: mdu_waddr, d: mdu_wdata, live: 1'b1});
    endtask

    task automatic tick();
        logic [31:0] e_pend;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        e_pend = '0;
        foreach (q[i]) if (q[i].live) e_pend[q[i].a] = 1'b1;
        check("we", {31'b0, we}, {31'b0, e_we});
        check("waddr", {27'b0, waddr}, {27'b0, e_waddr});
        check("wdata", wdata, e_wdata);
        check("fifo_cnt", {29'b0, fifo_cnt}, q.size());
        check("pend_mask", pend_mask, e_pend);
        check("mdu_ready", {31'b0, mdu_ready}, {31'b0, q.size() != DEPTH});
        if (we) dut_rf[waddr] = wdata;
    endtask

    task automatic idle();
        pipe_we = 1'b0;
        pipe_waddr = '0;
        mdu_valid = 1'b0;
        mdu_waddr = '0;
    endtask

    initial begin
        foreach (dut_rf[i]) dut_rf[i] = '0;
        // reset held two cycles with a hostile MDU request
        rst = 1'b0;
        mdu_valid = 1'b1;
        mdu_waddr = 5'd3;
        tick();
        tick();
        check("rst_pend", pend_mask, 32'h0);
        idle();
        rst = 1'b1;
        check("rst_ready", {31'b0, mdu_ready}, 32'h1);

        // pipeline write appears one cycle later
        pipe_we = 1'b1;
        pipe_waddr = 5'd5;
        pipe_wdata = 32'hDEADBEEF;
        tick();
        check("pipe_wdata", wdata, 32'hDEADBEEF);
        check("pipe_waddr", {27'b0, waddr}, 32'd5);

        // fill the FIFO while the pipeline keeps the port busy, then drain in order
        for (int k = 1; k <= 4; k++) begin
            pipe_we = 1'b1;
            pipe_waddr = 5'd9;
            pipe_wdata = 32'h900 + k;
            mdu_valid = 1'b1;
            mdu_waddr = 5'(k);
            mdu_wdata = 32'hA0 + k;
            tick();
        end
        check("full_cnt", {29'b0, fifo_cnt}, 32'd4);
        check("full_ready", {31'b0, mdu_ready}, 32'd0);
        check("full_pend", pend_mask, 32'h1E);
        idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("drain_addr", {27'b0, waddr}, k);
            check("drain_data", wdata, 32'hA0 + k);
        end
        check("drain_pend", pend_mask, 32'h0);

        // writes to r0 from either source are ignored
        pipe_we = 1'b1;
        pipe_waddr = 5'd0;
        mdu_valid = 1'b1;
        mdu_waddr = 5'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("r0_we", {31'b0, we}, 32'd0);
        end
        check("r0_cnt", {29'b0, fifo_cnt}, 32'd0);
        idle();

        // stale MDU result versus a newer pipeline write to the same register
        pipe_we = 1'b1;
        pipe_waddr = 5'd9;
        mdu_valid = 1'b1;
        mdu_waddr = 5'd7;
        mdu_wdata = 32'h11;
        tick();
        mdu_valid = 1'b0;
        pipe_waddr = 5'd7;
        pipe_wdata = 32'h22;
        tick();
`ifdef WB_KILL_STALE_EN
        check("stale_pend7", {31'b0, pend_mask[7]}, 32'd0);
`else
        check("stale_pend7", {31'b0, pend_mask[7]}, 32'd1);
`endif
        idle();
        tick();
        tick();
`ifdef WB_KILL_STALE_EN
        check("stale_r7", dut_rf[7], 32'h22);
`else
        check("stale_r7", dut_rf[7], 32'h11);
`endif

        // reset with three queued results discards them
        for (int k = 1; k <= 3; k++) begin
            pipe_we = 1'b1;
            pipe_waddr = 5'd9;
            mdu_valid = 1'b1;
            mdu_waddr = 5'(k + 10);
            mdu_wdata = 32'hB0 + k;
            tick();
        end
        check("pre_rst_cnt", {29'b0, fifo_cnt}, 32'd3);
        idle();
        mdu_valid = 1'b1;
        mdu_waddr = 5'd4;
        rst = 1'b0;
        tick();
        check("post_rst_cnt", {29'b0, fifo_cnt}, 32'd0);
        check("post_rst_we", {31'b0, we}, 32'd0);
        rst = 1'b1;
        idle();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_ghost_we", {31'b0, we}, 32'd0);
        end

        // randomized traffic, small address space to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            pipe_we = ($urandom_range(0, 1) == 1);
            pipe_waddr = 5'($urandom_range(0, 7));
            pipe_wdata = $urandom;
            mdu_valid = ($urandom_range(0, 9) < 6);
            mdu_waddr = 5'($urandom_range(0, 7));
            mdu_wdata = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
